// File: rtl/sm3_block_feeder.sv
// SM3 message front end: packs a byte stream into 512-bit blocks and applies
// SM3 padding (0x80, zero fill, 64-bit big-endian bit length).
module sm3_block_feeder #(
    parameter int DATA_BYTES = 1,
    parameter int LEN_W      = 61
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        msg_len,
    input  logic                    in_valid,
    input  logic [8*DATA_BYTES-1:0] in_data,
    output logic                    in_ready,
    output logic                    blk_valid,
    input  logic                    blk_ready,
    output logic [511:0]            blk_data,
    output logic                    blk_first,
    output logic                    blk_last,
    output logic                    busy,
    output logic                    done
);

    // state  | meaning
    // IDLE   | waiting for start
    // FILL   | accepting message beats into the block buffer
    // PAD    | placing 0x80 (and the length field if it fits)
    // LENBLK | overflow block: length field only
    // EMIT   | presenting the block to the compression core
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        PAD    = 3'd2,
        LENBLK = 3'd3,
        EMIT   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [0:63][7:0] blk_buf, buf_nxt;
    logic [6:0]       pos;
    logic [LEN_W-1:0] rem;
    logic [63:0]      bitlen;
    logic             first_q;
    logic             last_q;
    logic             pad_placed;
    logic             done_q;

    logic [6:0]       take;
    logic [6:0]       pos_fill;
    logic [LEN_W-1:0] rem_fill;

    // Final beat may carry fewer message bytes than the beat width.
    assign take     = (rem < LEN_W'(DATA_BYTES)) ? 7'(rem) : 7'(DATA_BYTES);
    assign pos_fill = pos + take;
    assign rem_fill = rem - LEN_W'(take);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (msg_len != '0) ? FILL : PAD;
                end
            end
            FILL: begin
                if (in_valid) begin
                    if (pos_fill == 7'd64) begin
                        state_nxt = EMIT;
                    end else if (rem_fill == '0) begin
                        state_nxt = PAD;
                    end
                end
            end
            PAD:    state_nxt = EMIT;
            LENBLK: state_nxt = EMIT;
            EMIT: begin
                if (blk_ready) begin
                    if (last_q) begin
                        state_nxt = IDLE;
                    end else if (rem != '0) begin
                        state_nxt = FILL;
                    end else if (!pad_placed) begin
                        state_nxt = PAD;
                    end else begin
                        state_nxt = LENBLK;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next buffer contents; bytes past the write position are always zero.
    always_comb begin
        buf_nxt = blk_buf;
        case (state)
            IDLE: begin
                if (start) begin
                    buf_nxt = '0;
                end
            end
            FILL: begin
                if (in_valid) begin
                    for (int b = 0; b < 64; b++) begin
                        for (int k = 0; k < DATA_BYTES; k++) begin
                            if ((7'(k) < take) && (7'(b) == pos + 7'(k))) begin
                                buf_nxt[b] = in_data[8*(DATA_BYTES-1-k) +: 8];
                            end
                        end
                    end
                end
            end
            PAD: begin
                for (int b = 0; b < 64; b++) begin
                    if (7'(b) == pos) begin
                        buf_nxt[b] = 8'h80;
                    end
                end
                if (pos <= 7'd55) begin
                    buf_nxt[56:63] = bitlen;
                end
            end
            LENBLK: buf_nxt[56:63] = bitlen;
            EMIT: begin
                if (blk_ready) begin
                    buf_nxt = '0;
                end
            end
            default: buf_nxt = blk_buf;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_buf    <= '0;
            pos        <= '0;
            rem        <= '0;
            bitlen     <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            pad_placed <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            blk_buf <= buf_nxt;
            done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rem        <= msg_len;
                        bitlen     <= 64'({msg_len, 3'b000});
                        pos        <= '0;
                        first_q    <= 1'b1;
                        last_q     <= 1'b0;
                        pad_placed <= 1'b0;
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        pos    <= pos_fill;
                        rem    <= rem_fill;
                        last_q <= 1'b0;
                    end
                end
                PAD: begin
                    pad_placed <= 1'b1;
                    last_q     <= (pos <= 7'd55);
                end
                LENBLK: last_q <= 1'b1;
                EMIT: begin
                    if (blk_ready) begin
                        pos     <= '0;
                        first_q <= 1'b0;
                        done_q  <= last_q;
                    end
                end
                default: begin
                    pos <= '0;
                end
            endcase
        end
    end

    assign in_ready  = (state == FILL);
    assign blk_valid = (state == EMIT);
    assign blk_data  = blk_buf;
    assign blk_first = blk_valid & first_q;
    assign blk_last  = blk_valid & last_q;
    assign busy      = (state != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_sm3_block_feeder.sv
// Directed bench for sm3_block_feeder (4-byte beats); expected padded blocks
// are built from the message bytes and compared as the DUT emits them.
module tb_sm3_block_feeder;

    localparam int DB = 4;
    localparam int LW = 61;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [LW-1:0]   msg_len = '0;
    logic            in_valid = 1'b0;
    logic [8*DB-1:0] in_data = '0;
    logic            blk_ready = 1'b0;
    logic            in_ready, blk_valid, blk_first, blk_last, busy, done;
    logic [511:0]    blk_data;

    sm3_block_feeder #(.DATA_BYTES(DB), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .msg_len   (msg_len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_last  (blk_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] data;
        logic         first;
        logic         last;
    } blk_t;

    blk_t       exp_q[$];
    logic [7:0] stream_q[$];
    logic       done_exp = 1'b0;
    int         pass_cnt = 0;
    int         total_cnt = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic gen_stream(input int len);
        stream_q.delete();
        for (int i = 0; i < ((len + DB - 1) / DB) * DB; i++)
            stream_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Reference SM3 padding of the first len stream bytes, split into blocks.
    task automatic push_expected(input int len);
        logic [7:0]  pad[$];
        logic [63:0] bl;
        blk_t        b;
        int          nb;
        for (int i = 0; i < len; i++) pad.push_back(stream_q[i]);
        pad.push_back(8'h80);
        while ((pad.size() % 64) != 56) pad.push_back(8'h00);
        bl = 64'(len) * 64'd8;
        for (int k = 7; k >= 0; k--) pad.push_back(bl[8*k +: 8]);
        nb = pad.size() / 64;
        for (int bi = 0; bi < nb; bi++) begin
            b.data = '0;
            for (int k = 0; k < 64; k++) b.data[511-8*k -: 8] = pad[bi*64+k];
            b.first = (bi == 0);
            b.last  = (bi == nb - 1);
            exp_q.push_back(b);
        end
    endtask

    // Block scoreboard and per-cycle protocol checks.
    always @(negedge clk) begin
        if (rst) begin
            done_exp = 1'b0;
        end else begin
            check("done_pulse", done, done_exp);
            check("no_beat_during_emit", in_ready & blk_valid, 0);
            if (blk_valid) begin
                check("block_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("blk_data", blk_data, exp_q[0].data);
                    check("blk_first_last", {blk_first, blk_last}, {exp_q[0].first, exp_q[0].last});
                    if (blk_ready) void'(exp_q.pop_front());
                end
            end
            done_exp = blk_valid && blk_ready && blk_last;
        end
    end

    task automatic run_msg(input int len, input int bp, input bit gaps, input bit poke);
        int beat = 0;
        int nbeats;
        int cyc = 0;
        int cnt = 0;
        bit finished = 0;
        bit acc;
        bit saw_rdy = 0;
        nbeats = (len + DB - 1) / DB;
        push_expected(len);
        msg_len = LW'(len);
        start = 1'b1;
        while (!finished && cyc < 3000) begin
            in_valid = (beat < nbeats) && (!gaps || $urandom_range(0, 3) != 0);
            if (beat < nbeats)
                for (int k = 0; k < DB; k++) in_data[8*(DB-1-k) +: 8] = stream_q[beat*DB+k];
            cnt = blk_valid ? cnt + 1 : 0;
            blk_ready = blk_valid && (cnt > bp);
            if (poke && cyc == 6) begin
                start = 1'b1;
                msg_len = LW'(3);
            end
            @(negedge clk);
            if (cyc == 1) check("busy_after_start", busy, 1);
            if (poke && cyc == 6) check("busy_at_ignored_start", busy, 1);
            acc = in_valid && in_ready;
            saw_rdy |= in_ready;
            if (done) begin
                finished = 1;
                check("busy_at_done", busy, 0);
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (acc) beat++;
            cyc++;
        end
        in_valid = 1'b0;
        blk_ready = 1'b0;
        check("msg_completed", finished, 1);
        check("all_blocks_emitted", exp_q.size(), 0);
        check("all_beats_taken", beat, nbeats);
        if (len == 0) check("no_in_ready_for_empty", saw_rdy, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {in_ready, blk_valid, blk_first, blk_last, busy, done}, 0);
        check("reset_blk_data", blk_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // "abc" with a junk fourth byte in the only beat
        gen_stream(3);
        stream_q[0] = 8'h61; stream_q[1] = 8'h62; stream_q[2] = 8'h63; stream_q[3] = 8'h5A;
        run_msg(3, 0, 0, 0);

        gen_stream(0);
        run_msg(0, 0, 0, 0);

        gen_stream(56);
        run_msg(56, 2, 1, 0);

        gen_stream(64);
        run_msg(64, 0, 0, 0);

        gen_stream(5);
        stream_q[4] = 8'hAA; stream_q[5] = 8'hBB; stream_q[6] = 8'hCC; stream_q[7] = 8'hDD;
        run_msg(5, 1, 0, 0);

        gen_stream(55);
        run_msg(55, 0, 1, 0);

        gen_stream(119);
        run_msg(119, 0, 0, 0);

        // long stall on every block plus a stray start while busy
        gen_stream(130);
        run_msg(130, 10, 1, 1);

        // reset in the middle of FILL
        gen_stream(20);
        msg_len = LW'(20);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        in_valid = 1'b1;
        in_data = {stream_q[0], stream_q[1], stream_q[2], stream_q[3]};
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("busy_in_fill", {busy, in_ready}, 2'b11);
        @(posedge clk);
        #1 rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_outputs", {in_ready, blk_valid, blk_first, blk_last, busy, done}, 0);
        check("abort_blk_data", blk_data, 0);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        gen_stream(20);
        run_msg(20, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
